sprite_rom_arbiter: RTL

- Round-robin arbiter sharing one synchronous sprite/level ROM (12-bit address) between up to N requesters.
- Typical requesters: the level address generator, player sprite fetch, enemy sprite fetch, bullet sprite fetch.
- Accepts at most one ROM read per pclk cycle.
- Tracks in-flight reads and returns each ROM word to the requester that issued it, with a per-requester valid pulse.

---
 rtl/sprite_rom_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite/level ROM between N_REQ requesters.
// A one-hot tag pipeline routes each returning ROM word back to the requester that issued it.
module sprite_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 12,
  parameter int ROM_LAT = 1
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic                    busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]                ptr;
  logic [N_REQ-1:0]                elig;
  logic                            win_vld;
  logic [PTR_W-1:0]                win_idx;
  logic [PTR_W-1:0]                ptr_nxt;
  logic [N_REQ-1:0]                win_oh;
  logic [ADDR_W-1:0]               win_addr;
  logic [ROM_LAT-1:0][N_REQ-1:0]   tag_p;

  // Returns {found, index} of the first set bit of e, searching p, p+1, ... modulo N_REQ.
  function automatic logic [PTR_W:0] rr_pick(input logic [N_REQ-1:0] e,
                                             input logic [PTR_W-1:0] p);
    logic [PTR_W:0] r;
    int             idx;
    r = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % N_REQ;
      if (e[idx]) r = {1'b1, PTR_W'(idx)};
    end
    return r;
  endfunction

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v);
    return (int'(v) == N_REQ - 1) ? '0 : v + 1'b1;
  endfunction

  // A requester granted last edge is still showing req this cycle; mask it.
  assign elig = req & ~gnt;

  always_comb begin
    {win_vld, win_idx} = rr_pick(elig, ptr);
    ptr_nxt  = wrap_inc(win_idx);
    win_oh   = '0;
    win_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_vld && int'(win_idx) == i) begin
        win_oh[i] = 1'b1;
        win_addr  = addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Stage p0: grant and ROM address registered; stages p1..p(ROM_LAT) carry the grant tag.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      gnt      <= '0;
      rom_addr <= '0;
      ptr      <= '0;
      tag_p    <= '0;
    end else begin
      gnt <= win_oh;
      if (win_vld) begin
        rom_addr <= win_addr;
        ptr      <= ptr_nxt;
      end
      tag_p[0] <= gnt;
      for (int s = 1; s < ROM_LAT; s++) begin
        tag_p[s] <= tag_p[s-1];
      end
    end
  end

  assign rvalid = tag_p[ROM_LAT-1];
  assign rdata  = rom_data;
  assign busy   = (|gnt) | (|tag_p);

endmodule
